// File: rtl/mem_pkg.sv
// Shared types and default geometry for the line-wide memory responder.
// The responder and its line array derive their own widths from these.
package mem_pkg;

  localparam int DEF_BITSIZE  = 32;
  localparam int DEF_WORDS    = 4;
  localparam int DEF_MEM_SIZE = 1024;
  localparam int DEF_LATENCY  = 2;

  localparam int LINE_W     = DEF_BITSIZE * DEF_WORDS;
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int IDX_W      = $clog2(DEF_MEM_SIZE);
  localparam int CNT_W      = $clog2(DEF_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_if.sv
// Controller-to-memory request/response bundle, four-phase handshake.
// The master drives the request side, the slave answers it.
interface mem_if
  import mem_pkg::*;
#(
  parameter int W = LINE_W
);

  logic [31:0]  mem_addr_i;
  logic [W-1:0] mem_data_i;
  logic         mem_store_i;
  logic         mem_valid_i;
  logic [W-1:0] mem_data_o;
  logic         mem_valid_o;
  logic         mem_err_o;
  logic         mem_busy_o;

  modport master (
    output mem_addr_i,
    output mem_data_i,
    output mem_store_i,
    output mem_valid_i,
    input  mem_data_o,
    input  mem_valid_o,
    input  mem_err_o,
    input  mem_busy_o
  );

  modport slave (
    input  mem_addr_i,
    input  mem_data_i,
    input  mem_store_i,
    input  mem_valid_i,
    output mem_data_o,
    output mem_valid_o,
    output mem_err_o,
    output mem_busy_o
  );

endinterface

// File: rtl/mem_line_array.sv
// Single-port line RAM: one write port and a registered read port.
// Contents are not reset; only the read register follows idx each edge.
module mem_line_array
  import mem_pkg::*;
#(
  parameter int W     = LINE_W,
  parameter int DEPTH = DEF_MEM_SIZE,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // write on request, read the addressed line every edge
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: capture a request, commit it after LATENCY
// edges, then hold the response until the initiator drops valid.
module mem_responder
  import mem_pkg::*;
#(
  parameter int BITSIZE          = DEF_BITSIZE,
  parameter int N_WORDS_PER_ADDR = DEF_WORDS,
  parameter int MEM_SIZE         = DEF_MEM_SIZE,
  parameter int LATENCY          = DEF_LATENCY
) (
  input logic  clk,
  input logic  reset_i,
  mem_if.slave bus
);

  localparam int LW    = BITSIZE * N_WORDS_PER_ADDR;
  localparam int OFF_W = $clog2(LW / 8);
  localparam int IW    = $clog2(MEM_SIZE);
  localparam int CW    = $clog2(LATENCY + 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [IW-1:0] cap_idx;
  logic          cap_store;
  logic          cap_err;
  logic [LW-1:0] cap_data;
  logic [31:0]   line;
  logic          in_range;
  logic          capture;
  logic          commit;
  logic          we;
  logic [IW-1:0] ram_idx;
  logic [LW-1:0] rdata;
  logic          valid_q;
  logic          err_q;
  logic          busy_q;
  logic [LW-1:0] data_q;

  assign line     = bus.mem_addr_i >> OFF_W;
  assign in_range = line < 32'(MEM_SIZE);
  assign capture  = (state == IDLE) && bus.mem_valid_i;
  assign we       = commit && cap_store && !cap_err;

  // While idle the RAM reads the incoming line so a LATENCY of 1
  // still has the right data registered by the commit edge.
  assign ram_idx = (state == IDLE) ? line[IW-1:0] : cap_idx;

  mem_line_array #(
    .W     (LW),
    .DEPTH (MEM_SIZE)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (ram_idx),
    .wdata (cap_data),
    .rdata (rdata)
  );

  // next state; commit fires on the last counted WAIT edge
  always_comb begin
    state_n = state;
    commit  = 1'b0;
    unique case (state)
      IDLE: if (bus.mem_valid_i) state_n = WAIT;
      WAIT: begin
        if (!bus.mem_valid_i) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          state_n = RESP;
          commit  = 1'b1;
        end
      end
      RESP: if (!bus.mem_valid_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  // request capture and latency countdown
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      cnt       <= '0;
      cap_idx   <= '0;
      cap_store <= 1'b0;
      cap_err   <= 1'b0;
      cap_data  <= '0;
    end else if (capture) begin
      cnt       <= CW'(LATENCY - 1);
      cap_idx   <= line[IW-1:0];
      cap_store <= bus.mem_store_i;
      cap_err   <= !in_range;
      cap_data  <= bus.mem_data_i;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // registered response, held until the initiator withdraws
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_n != IDLE);
      if (commit) begin
        valid_q <= 1'b1;
        err_q   <= cap_err;
        data_q  <= (cap_store || cap_err) ? '0 : rdata;
      end else if (state == RESP && !bus.mem_valid_i) begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        data_q  <= '0;
      end
    end
  end

  assign bus.mem_valid_o = valid_q;
  assign bus.mem_err_o   = err_q;
  assign bus.mem_data_o  = data_q;
  assign bus.mem_busy_o  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder at LATENCY 1, 2 and 3 against a
// transaction-level model, plus directed literal checks.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  mem_if #(.W(128)) b0 ();
  mem_if #(.W(128)) b1 ();
  mem_if #(.W(128)) b2 ();

  mem_responder #(.LATENCY(1)) u0 (.clk(clk), .reset_i(rst), .bus(b0));
  mem_responder #(.LATENCY(2)) u1 (.clk(clk), .reset_i(rst), .bus(b1));
  mem_responder #(.LATENCY(3)) u2 (.clk(clk), .reset_i(rst), .bus(b2));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(int k, bit v, logic [31:0] a, bit s, logic [127:0] d);
    case (k)
      0: begin
        b0.mem_valid_i = v; b0.mem_addr_i = a;
        b0.mem_store_i = s; b0.mem_data_i = d;
      end
      1: begin
        b1.mem_valid_i = v; b1.mem_addr_i = a;
        b1.mem_store_i = s; b1.mem_data_i = d;
      end
      default: begin
        b2.mem_valid_i = v; b2.mem_addr_i = a;
        b2.mem_store_i = s; b2.mem_data_i = d;
      end
    endcase
  endtask

  function automatic logic in_v(int k);
    case (k)
      0: return b0.mem_valid_i;
      1: return b1.mem_valid_i;
      default: return b2.mem_valid_i;
    endcase
  endfunction

  function automatic logic [31:0] in_a(int k);
    case (k)
      0: return b0.mem_addr_i;
      1: return b1.mem_addr_i;
      default: return b2.mem_addr_i;
    endcase
  endfunction

  function automatic logic in_s(int k);
    case (k)
      0: return b0.mem_store_i;
      1: return b1.mem_store_i;
      default: return b2.mem_store_i;
    endcase
  endfunction

  function automatic logic [127:0] in_d(int k);
    case (k)
      0: return b0.mem_data_i;
      1: return b1.mem_data_i;
      default: return b2.mem_data_i;
    endcase
  endfunction

  function automatic logic out_v(int k);
    case (k)
      0: return b0.mem_valid_o;
      1: return b1.mem_valid_o;
      default: return b2.mem_valid_o;
    endcase
  endfunction

  function automatic logic out_e(int k);
    case (k)
      0: return b0.mem_err_o;
      1: return b1.mem_err_o;
      default: return b2.mem_err_o;
    endcase
  endfunction

  function automatic logic out_b(int k);
    case (k)
      0: return b0.mem_busy_o;
      1: return b1.mem_busy_o;
      default: return b2.mem_busy_o;
    endcase
  endfunction

  function automatic logic [127:0] out_d(int k);
    case (k)
      0: return b0.mem_data_o;
      1: return b1.mem_data_o;
      default: return b2.mem_data_o;
    endcase
  endfunction

  // Transaction-level model: a request is outstanding from its capture
  // cycle; it completes (k+1) cycles later unless valid drops first.
  bit           act [3];
  bit           rsp [3];
  int           tcap [3];
  int           cidx [3];
  bit           cst [3];
  bit           cerr [3];
  logic [127:0] cdat [3];
  bit           ev [3];
  bit           ee [3];
  bit           edk [3];
  logic [127:0] ed [3];
  logic [127:0] mm [int];
  int           cyc = 0;

  task automatic model_step(int k);
    logic [31:0] a;
    if (rsp[k]) begin
      if (!in_v(k)) begin
        rsp[k] = 0; ev[k] = 0; ee[k] = 0; ed[k] = '0; edk[k] = 1;
      end
    end else if (act[k]) begin
      if (!in_v(k)) begin
        act[k] = 0;
      end else if (cyc == tcap[k] + k + 1) begin
        act[k] = 0; rsp[k] = 1; ev[k] = 1; ee[k] = cerr[k];
        ed[k] = '0; edk[k] = 1;
        if (!cerr[k]) begin
          if (cst[k]) mm[k*2048 + cidx[k]] = cdat[k];
          else if (mm.exists(k*2048 + cidx[k])) ed[k] = mm[k*2048 + cidx[k]];
          else edk[k] = 0;
        end
      end
    end else if (in_v(k)) begin
      a       = in_a(k);
      act[k]  = 1;
      tcap[k] = cyc;
      cerr[k] = (a / 16) >= 32'd1024;
      cidx[k] = int'(a / 16);
      cst[k]  = in_s(k);
      cdat[k] = in_d(k);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        act[k] = 0; rsp[k] = 0; ev[k] = 0; ee[k] = 0;
        ed[k] = '0; edk[k] = 1;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  always begin
    @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d valid_o", k), 128'(out_v(k)), 128'(ev[k]));
      chk($sformatf("u%0d err_o", k), 128'(out_e(k)), 128'(ee[k]));
      chk($sformatf("u%0d busy_o", k), 128'(out_b(k)), 128'(act[k] | rsp[k]));
      if (edk[k]) chk($sformatf("u%0d data_o", k), out_d(k), ed[k]);
    end
  end

  task automatic dir_txn(int k, logic [31:0] a, bit s, logic [127:0] d,
                         int elat, logic [127:0] edat, bit eerr, bit scr,
                         string nm);
    int seen;
    seen = -1;
    @(negedge clk);
    drive(k, 1, a, s, d);
    @(posedge clk);
    for (int i = 1; i <= 12; i++) begin
      if (scr) begin
        @(negedge clk);
        drive(k, 1, $urandom, 1'($urandom), {4{$urandom}});
      end
      @(posedge clk);
      #2;
      if (out_v(k)) begin
        seen = i;
        break;
      end
    end
    chk({nm, " latency"}, 128'(seen), 128'(elat));
    chk({nm, " data"}, out_d(k), edat);
    chk({nm, " err"}, 128'(out_e(k)), 128'(eerr));
    @(negedge clk);
    if (scr) drive(k, 1, $urandom, 1'($urandom), {4{$urandom}});
    @(posedge clk);
    #2;
    chk({nm, " hold valid"}, 128'(out_v(k)), 128'(1));
    chk({nm, " hold data"}, out_d(k), edat);
    @(negedge clk);
    drive(k, 0, '0, 0, '0);
    @(posedge clk);
    #2;
    chk({nm, " drop valid"}, 128'(out_v(k)), 128'(0));
    chk({nm, " drop data"}, out_d(k), 128'(0));
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    logic [31:0] off;
    r = int'($urandom_range(0, 9));
    off = $urandom_range(0, 15);
    if (r < 7) return ($urandom_range(0, 7) << 4) | off;
    if (r == 7) return 32'h3FF0 | off;
    if (r == 8) return ((32'd1024 + $urandom_range(0, 3)) << 4) | off;
    return $urandom;
  endfunction

  task automatic rand_loop(int k, int n);
    for (int t = 0; t < n; t++) begin
      int hold;
      int gap;
      hold = int'($urandom_range(1, k + 5));
      @(negedge clk);
      drive(k, 1, pick_addr(), 1'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
      @(posedge clk);
      for (int i = 1; i <= hold; i++) begin
        @(negedge clk);
        if (i == hold) drive(k, 0, $urandom, 0, '0);
        else if ($urandom_range(0, 3) == 0)
          drive(k, 1, pick_addr(), 1'($urandom), {4{$urandom}});
      end
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
    end
  endtask

  localparam logic [127:0] D2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D3 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D4 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] D5 = 128'h0BADC0DE_FEEDFACE_12345678_9ABCDEF0;
  localparam logic [127:0] D6 = 128'h600DF00D_0000FFFF_13572468_ACE0BDF1;

  initial begin
    int seen;
    for (int k = 0; k < 3; k++) drive(k, 1, '0, 0, '0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst u%0d valid", k), 128'(out_v(k)), 128'(0));
      chk($sformatf("rst u%0d busy", k), 128'(out_b(k)), 128'(0));
    end
    chk("rst u1 data", out_d(1), 128'(0));
    chk("rst u1 err", 128'(out_e(1)), 128'(0));
    rst = 1'b0;
    #1;
    chk("rst release idle", 128'(out_b(1)), 128'(0));
    @(posedge clk);
    #2;
    chk("first capture", 128'(out_b(1)), 128'(1));
    @(negedge clk);
    for (int k = 0; k < 3; k++) drive(k, 0, '0, 0, '0);
    @(posedge clk);
    #2;
    chk("early abort", 128'(out_b(1)), 128'(0));

    dir_txn(1, 32'h50, 1, D2, 2, '0, 0, 0, "t2 store");
    dir_txn(1, 32'h5C, 0, '0, 2, D2, 0, 0, "t2 load");

    dir_txn(2, 32'h10, 1, D3, 3, '0, 0, 0, "t3 pre");
    @(negedge clk);
    drive(2, 1, 32'h10, 1, '1);
    @(posedge clk);
    @(negedge clk);
    drive(2, 0, '0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      chk("t3 no pulse", 128'(out_v(2)), 128'(0));
    end
    dir_txn(2, 32'h10, 0, '0, 3, D3, 0, 0, "t3 load");

    dir_txn(1, 32'h0, 1, D4, 2, '0, 0, 0, "t4 line0");
    dir_txn(1, 32'h4000, 0, '0, 2, '0, 1, 0, "t4 oor load");
    dir_txn(1, 32'h4000, 1, '1, 2, '0, 1, 0, "t4 oor store");
    dir_txn(1, 32'h8, 0, '0, 2, D4, 0, 0, "t4 line0 load");

    dir_txn(0, 32'h30, 1, D5, 1, '0, 0, 1, "t5 store l1");
    dir_txn(0, 32'h3F, 0, '0, 1, D5, 0, 1, "t5 load l1");
    dir_txn(2, 32'h30, 1, ~D5, 3, '0, 0, 1, "t5 store l3");
    dir_txn(2, 32'h34, 0, '0, 3, ~D5, 0, 1, "t5 load l3");

    @(negedge clk);
    drive(1, 1, 32'h200, 1, D6);
    @(posedge clk);
    seen = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #2;
      if (out_v(1)) begin
        seen = i;
        break;
      end
    end
    chk("t6 latency", 128'(seen), 128'(2));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6 async valid", 128'(out_v(1)), 128'(0));
    chk("t6 async busy", 128'(out_b(1)), 128'(0));
    chk("t6 async data", out_d(1), 128'(0));
    @(negedge clk);
    drive(1, 0, '0, 0, '0);
    @(negedge clk);
    rst = 1'b0;
    dir_txn(1, 32'h200, 0, '0, 2, D6, 0, 0, "t6 load");

    fork
      rand_loop(0, 250);
      rand_loop(1, 250);
      rand_loop(2, 250);
    join
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
